// File: rtl/cache_arbiter.sv
// Arbitrates the icache/dcache miss paths onto one line-wide memory port; one transaction in flight, mem latency + 1 cycle.
// Requesters hold until resp; define CACHE_ARB_ROUND_ROBIN_EN to alternate grants on conflict (default: dcache wins).
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wdata_q;
    logic                    wr_q;
    logic                    d_req;
    logic                    grant_d;
    logic                    grant_i;
    logic                    serve_i;
    logic                    serve_d;

    assign d_req = d_read | d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic last_d;

    // On conflict the side not served last wins; a lone requester always wins.
    assign grant_d = d_req & ~(i_read & last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d <= 1'b1;
        end else if (state == IDLE && grant_d) begin
            last_d <= 1'b1;
        end else if (state == IDLE && grant_i) begin
            last_d <= 1'b0;
        end
    end
`else
    assign grant_d = d_req;
`endif

    assign grant_i = i_read & ~grant_d;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = SERVE_D;
                end else if (grant_i) begin
                    state_nxt = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            // Write wins when the dcache raises read and write together.
            if (state == IDLE && grant_d) begin
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                wr_q    <= d_write;
            end else if (state == IDLE && grant_i) begin
                addr_q <= i_addr;
                wr_q   <= 1'b0;
            end
        end
    end

    assign serve_i = (state == SERVE_I);
    assign serve_d = (state == SERVE_D);

    // Memory side sees only registered state, never the live request lines.
    assign mem_read  = serve_i | (serve_d & ~wr_q);
    assign mem_write = serve_d & wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign i_resp  = serve_i & mem_resp;
    assign d_resp  = serve_d & mem_resp;
    assign i_rdata = serve_i ? mem_rdata : '0;
    assign d_rdata = serve_d ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized scoreboard bench for cache_arbiter: a reference model predicts service order and line data,
// a memory responder with random latency plays the memory side, and a monitor checks everything the DUT presents.
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } mem_txn_t;

    typedef struct {
        bit            is_d;
        bit            chk_data;
        logic [LW-1:0] data;
    } resp_t;

    mem_txn_t exp_mem[$];
    resp_t    exp_resp[$];

    logic [LW-1:0] phys_mem [logic [AW-1:0]];
    logic [LW-1:0] ref_mem  [logic [AW-1:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int force_lat = 0;
    bit stray    = 1'b0;
    bit last_d   = 1'b1;

    function automatic logic [LW-1:0] fresh_line(logic [AW-1:0] a);
        logic [31:0] w;
        w = a * 32'h9E37_79B1 + 32'h1234_5678;
        return {8{w}};
    endfunction

    function automatic logic [LW-1:0] ref_read(logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return fresh_line(a);
    endfunction

    task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Memory responder: random 1..4 cycle latency unless force_lat is set; drops everything on rst.
    initial begin
        int cnt;
        int lat;
        cnt = 0;
        lat = 1;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                mem_resp = 1'b0;
                cnt      = 0;
            end else if (mem_resp) begin
                mem_resp = 1'b0;
                cnt      = 0;
            end else if (mem_read || mem_write) begin
                cnt++;
                if (cnt == 1) lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
                if (cnt >= lat) begin
                    mem_resp = 1'b1;
                    if (mem_write) begin
                        phys_mem[mem_addr] = mem_wdata;
                        mem_rdata = {8{$urandom()}};
                    end else begin
                        mem_rdata = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : fresh_line(mem_addr);
                    end
                end
            end else if (stray) begin
                mem_resp  = 1'b1;
                mem_rdata = {8{$urandom()}};
            end
        end
    end

    // Monitor: pops expectations whenever the DUT starts a memory transaction or raises a resp.
    initial begin
        bit       prev_stb;
        bit       prev_resp;
        bit       have_cur;
        bit       stb;
        mem_txn_t cur;
        resp_t    e;
        prev_stb  = 1'b0;
        prev_resp = 1'b0;
        have_cur  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stb  = 1'b0;
                prev_resp = 1'b0;
                have_cur  = 1'b0;
                continue;
            end
            stb = mem_read | mem_write;
            if (prev_resp) chk("strobe_after_resp", LW'(stb), '0);
            if (stb && !prev_stb) begin
                if (exp_mem.size() == 0) begin
                    fail_now("unexpected_mem_txn");
                    have_cur = 1'b0;
                end else begin
                    cur      = exp_mem.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (stb && have_cur) begin
                chk("mem_op", LW'({mem_write, mem_read}), cur.wr ? LW'(2'b10) : LW'(2'b01));
                chk("mem_addr", LW'(mem_addr), LW'(cur.addr));
                if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
            end
            if (i_resp || d_resp) begin
                chk("resp_exclusive", LW'(i_resp & d_resp), '0);
                if (exp_resp.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    e = exp_resp.pop_front();
                    chk("resp_side_d", LW'(d_resp), LW'(e.is_d));
                    if (e.is_d) begin
                        if (e.chk_data) chk("d_rdata", d_rdata, e.data);
                        chk("i_rdata_idle", i_rdata, '0);
                    end else begin
                        chk("i_rdata", i_rdata, e.data);
                        chk("d_rdata_idle", d_rdata, '0);
                    end
                end
            end
            prev_stb  = stb;
            prev_resp = i_resp | d_resp;
        end
    end

    task automatic model_i(logic [AW-1:0] ia);
        exp_mem.push_back('{wr: 1'b0, addr: ia, wdata: '0});
        exp_resp.push_back('{is_d: 1'b0, chk_data: 1'b1, data: ref_read(ia)});
        last_d = 1'b0;
    endtask

    task automatic model_d(bit wr, logic [AW-1:0] da, logic [LW-1:0] dw);
        exp_mem.push_back('{wr: wr, addr: da, wdata: dw});
        if (wr) ref_mem[da] = dw;
        exp_resp.push_back('{is_d: 1'b1, chk_data: !wr, data: wr ? '0 : ref_read(da)});
        last_d = 1'b1;
    endtask

    task automatic drive_i(logic [AW-1:0] ia, bit solo);
        bit got;
        got    = 1'b0;
        i_read = 1'b1;
        i_addr = ia;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (solo && c == 0) chk("i_no_comb_path", LW'(mem_read | mem_write), '0);
            if (solo && c == 1) chk("i_strobe_next_cycle", LW'(mem_read), LW'(1'b1));
            if (i_resp) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("i_resp_timeout");
        @(posedge clk);
        #1;
        i_read = 1'b0;
    endtask

    task automatic drive_d(bit rd, bit wr, logic [AW-1:0] da, logic [LW-1:0] dw, bit solo, bit scramble);
        bit got;
        bit done_scr;
        got      = 1'b0;
        done_scr = 1'b0;
        d_read   = rd;
        d_write  = wr;
        d_addr   = da;
        d_wdata  = dw;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (solo && c == 0) chk("d_no_comb_path", LW'(mem_read | mem_write), '0);
            if (solo && c == 1) chk("d_strobe_next_cycle", LW'(mem_read | mem_write), LW'(1'b1));
            if (d_resp) begin
                got = 1'b1;
                break;
            end
            if (scramble && !done_scr && (mem_read || mem_write)) begin
                d_addr   = 32'h0000_3000;
                d_wdata  = ~dw;
                done_scr = 1'b1;
            end
        end
        if (!got) fail_now("d_resp_timeout");
        @(posedge clk);
        #1;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    // Requests raised together from IDLE; the model decides the service order from the priority rule.
    task automatic run_round(bit use_i, bit use_d, bit d_rd, bit d_wr, logic [AW-1:0] ia,
                             logic [AW-1:0] da, logic [LW-1:0] dw, bit scramble);
        bit d_first;
        if (use_i && use_d) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            d_first = !last_d;
`else
            d_first = 1'b1;
`endif
        end else begin
            d_first = use_d;
        end
        for (int k = 0; k < 2; k++) begin
            if ((k == 0) == d_first) begin
                if (use_d) model_d(d_wr, da, dw);
            end else begin
                if (use_i) model_i(ia);
            end
        end
        fork
            begin
                if (use_i) drive_i(ia, !use_d);
            end
            begin
                if (use_d) drive_d(d_rd, d_wr, da, dw, !use_i, scramble);
            end
        join
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        i_read  = 1'b0;
        i_addr  = '0;
        d_read  = 1'b0;
        d_write = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_mem_read", LW'(mem_read), '0);
            chk("idle_mem_write", LW'(mem_write), '0);
            chk("idle_resp", LW'({i_resp, d_resp}), '0);
        end

        @(posedge clk);
        #1;
        stray = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stray_mem_resp_ignored", LW'({i_resp, d_resp, mem_read, mem_write}), '0);
        @(posedge clk);
        #1;
        stray = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        force_lat = 3;
        phys_mem[32'h60] = {32{8'hAB}};
        ref_mem[32'h60]  = {32{8'hAB}};
        run_round(1'b1, 1'b0, 1'b0, 1'b0, 32'h60, '0, '0, 1'b0);
        force_lat = 0;

        run_round(1'b0, 1'b1, 1'b0, 1'b1, '0, 32'h1000, {32{8'h5A}}, 1'b1);
        run_round(1'b0, 1'b1, 1'b1, 1'b0, '0, 32'h1000, '0, 1'b0);
        run_round(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200, '0, 1'b0);
        run_round(1'b0, 1'b1, 1'b1, 1'b1, '0, 32'h200, {8{32'hDEAD_BEEF}}, 1'b0);
        run_round(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200, '0, 1'b0);

        force_lat = 20;
        exp_mem.push_back('{wr: 1'b0, addr: 32'h40, wdata: '0});
        i_read = 1'b1;
        i_addr = 32'h40;
        repeat (3) begin @(posedge clk); #1; end
        rst    = 1'b1;
        i_read = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        last_d = 1'b1;
        @(negedge clk);
        chk("rst_midop_mem_read", LW'(mem_read), '0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_midop_no_resp", LW'({i_resp, d_resp}), '0);
        end
        force_lat = 0;
        @(posedge clk);
        #1;

        for (int r = 0; r < 60; r++) begin
            int            pat;
            bit            rd;
            bit            wr;
            logic [AW-1:0] ia;
            logic [AW-1:0] da;
            logic [LW-1:0] dw;
            pat = int'($urandom_range(0, 2));
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            ia = AW'($urandom_range(0, 15)) << 5;
            da = AW'($urandom_range(0, 15)) << 5;
            dw = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            run_round(pat != 1, pat != 0, rd, wr, ia, da, dw, (pat == 1) && ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) @(negedge clk);
        chk("exp_mem_drained", LW'(exp_mem.size()), '0);
        chk("exp_resp_drained", LW'(exp_resp.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single cacheline-wide physical-memory port between the icache miss path (read-only) and the dcache miss/writeback path (read/write).
- Sits below both caches and above physical memory / L2, next to the core top that wires the datapath to the caches.
- One transaction in flight at a time. The request is captured at grant and held stable on the memory port until that port responds.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits for all rdata/wdata buses.
- ADDR_WIDTH, 32, address width; addresses are line-aligned, low bits passed through unmodified.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- i_read  input  1  icache line-fill request
- i_addr  input  ADDR_WIDTH  icache line address
- i_rdata  output  LINE_WIDTH  fill data to icache
- i_resp  output  1  icache transaction complete
- d_read  input  1  dcache line-fill request
- d_write  input  1  dcache writeback request
- d_addr  input  ADDR_WIDTH  dcache line address
- d_wdata  input  LINE_WIDTH  dcache writeback data
- d_rdata  output  LINE_WIDTH  fill data to dcache
- d_resp  output  1  dcache transaction complete
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  LINE_WIDTH  memory write data
- mem_rdata  input  LINE_WIDTH  memory read data
- mem_resp  input  1  memory transaction complete

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high on rst.
- State machine: IDLE, SERVE_I, SERVE_D.
- Reset effects:
  - state goes to IDLE; mem_read, mem_write, i_resp, d_resp are all 0.
  - Captured addr/wdata registers are cleared to 0; last-served flag is cleared to "d".
  - Reset mid-transaction abandons it without asserting any resp. The memory model must discard its own in-flight state on rst.
- IDLE grant (evaluated each cycle in IDLE):
  - If (d_read|d_write) and no conflict, go to SERVE_D.
  - Else if i_read, go to SERVE_I.
  - Else stay in IDLE.
  - Conflict (both requesting): resolved by priority; default fixed priority favours dcache.
- Capture: on the grant edge, register addr; for dcache also register wdata and op (write if d_write, else read). d_write and d_read both high: write wins.
- Memory port:
  - Driven only from registered state and the captured values; no combinational path from requester inputs to mem_* outputs.
  - Requester asserts in cycle N (state IDLE). mem_read or mem_write is 1 from cycle N+1 until the cycle mem_resp is seen, inclusive.
- Response:
  - mem_resp in cycle M (state SERVE_x) drives x_resp=1 combinationally in cycle M, and x_rdata=mem_rdata in that cycle.
  - State returns to IDLE at M+1; mem strobes are 0 at M+1.
  - Minimum per-transaction latency: mem latency + 1 cycle.
- Routing rules:
  - i_resp and d_resp are never both 1.
  - The non-selected resp is 0.
  - Each rdata output is mem_rdata when that requester is served, else 0.
- Requester obligations:
  - Hold request and addr/wdata stable until resp.
  - Deassert or present a new request by cycle M+1.
  - A held-high request at M+1 is treated as a new request.
- mem_resp outside SERVE states is ignored.
- Requests that arrive during a SERVE state wait; there is no queueing beyond the level-sensitive request lines.

Optional Feature:
- Macro: CACHE_ARB_ROUND_ROBIN_EN.
- Defined: on conflict in IDLE, grant goes to the requester not served last. The last-served flag updates at each grant.
- Undefined: fixed dcache priority; the last-served flag is not implemented. The icache can starve under continuous dcache traffic; this is acceptable for the baseline build.

Test Plan:
- Reset then idle: rst 1 for 2 cycles, no requests -> mem_read=mem_write=0, i_resp=d_resp=0, state IDLE for 10 cycles.
- Single icache fill: i_read=1, i_addr=0x0000_0060; mem returns 0xAB..AB after 3 cycles -> mem_read=1 with mem_addr=0x60 from next cycle; i_resp=1 and i_rdata=0xAB..AB in mem_resp cycle; mem_read=0 the following cycle.
- Dcache writeback: d_write=1, d_addr=0x0000_1000, d_wdata=0x5A..5A -> mem_write=1, mem_addr=0x1000, mem_wdata=0x5A..5A; d_resp pulses 1 cycle on mem_resp; i_resp stays 0.
- Simultaneous requests: i_read and d_read in the same cycle, addrs 0x100/0x200.
  - Baseline: dcache served first (mem_addr=0x200), then icache (0x100).
  - With CACHE_ARB_ROUND_ROBIN_EN after a prior dcache transaction: icache first.
- Stability: change d_addr to 0x3000 mid-transaction -> mem_addr stays at the captured 0x1000 until mem_resp.
- Reset mid-op: rst during SERVE_I before mem_resp -> next cycle mem_read=0, state IDLE, no i_resp ever issued for that request.
